// File: rtl/rv32_multicycle_sequencer.sv
// rtl/rv32_multicycle_sequencer.sv - multi-cycle RV32 control sequencer with bounded memory handshakes
module rv32_multicycle_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_jump,
    input  logic [31:0] jump_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        alu_en,
    output logic        rf_write,
    output logic [31:0] pc,
    output logic        retire,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_FAULT
    } state_t;

    // Counter only ever needs to reach TIMEOUT-1 before the FSM leaves the wait state.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   pc_q;
    logic [31:0]   instr_q;

    logic is_nop;
    logic jump_misaligned;
    logic wait_expired;

    assign is_nop          = (instr_q == 32'h0);
    assign jump_misaligned = dec_jump && (jump_target[1:0] != 2'b00);
    assign wait_expired    = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q  <= imem_rdata;
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state    <= S_FAULT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    state <= is_nop ? S_WRITEBACK : S_EXECUTE;
                end
                S_EXECUTE: begin
                    state <= (dec_mem_read || dec_mem_write) ? S_MEM : S_WRITEBACK;
                end
                S_MEM: begin
                    // A decode claiming both load and store is illegal regardless of ready.
                    if (dec_mem_read && dec_mem_write) begin
                        state    <= S_FAULT;
                        wait_cnt <= '0;
                    end else if (dmem_ready) begin
                        state    <= S_WRITEBACK;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state    <= S_FAULT;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (jump_misaligned) begin
                        state <= S_FAULT;
                    end else begin
                        state <= S_FETCH;
                        pc_q  <= dec_jump ? jump_target : pc_q + 32'd4;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign dmem_req    = (state == S_MEM);
    assign dmem_we     = dmem_req && dec_mem_write;
    assign alu_en      = (state == S_EXECUTE);
    assign retire      = (state == S_WRITEBACK) && !jump_misaligned;
    assign rf_write    = retire && dec_reg_write && !is_nop;
    assign fault       = (state == S_FAULT);
    assign pc          = pc_q;

endmodule

// File: tb/tb_rv32_multicycle_sequencer.sv
// tb/tb_rv32_multicycle_sequencer.sv - scoreboard bench for rv32_multicycle_sequencer
module tb_rv32_multicycle_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_jump;
    logic [31:0] jump_target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        alu_en;
    logic        rf_write;
    logic [31:0] pc;
    logic        retire;
    logic        fault;

    always #5 clk = ~clk;

    rv32_multicycle_sequencer #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .dec_mem_read (dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write),
        .dec_jump     (dec_jump),
        .jump_target  (jump_target),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .alu_en       (alu_en),
        .rf_write     (rf_write),
        .pc           (pc),
        .retire       (retire),
        .fault        (fault)
    );

    // One program entry: the word served, what the decoder reports, and memory wait states.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] tgt;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        jmp;
        int          wf;
        int          wm;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        chk_instr;
        logic        rf;
        logic        we;
        logic        flt;
        int          alu;
        int          dm;
        int          lat;
    } exp_t;

    op_t         prog[$];
    exp_t        expq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          last_fault;
    logic [31:0] last_fault_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input int kind, input logic [31:0] tgt, input int wf, input int wm);
        op_t         o;
        logic [31:0] r;
        logic [6:0]  opc;
        r     = $urandom();
        opc   = 7'b0000000;
        o.rd  = 1'b0;
        o.wr  = 1'b0;
        o.rw  = 1'b0;
        o.jmp = 1'b0;
        o.tgt = tgt;
        o.wf  = wf;
        o.wm  = wm;
        case (kind)
            0: o.rw = 1'b1;
            1: begin opc = 7'b0110011; o.rw = 1'b1; end
            2: begin opc = 7'b0000011; o.rd = 1'b1; o.rw = 1'b1; end
            3: begin opc = 7'b0100011; o.wr = 1'b1; end
            4: begin opc = 7'b1101111; o.jmp = 1'b1; o.rw = 1'b1; end
            default: begin opc = 7'b0000011; o.rd = 1'b1; o.wr = 1'b1; o.rw = 1'b1; end
        endcase
        o.instr = (kind == 0) ? 32'h0 : {r[31:7], opc};
        return o;
    endfunction

    // Reference model: walks the program and predicts each retire or the terminating fault.
    task automatic build_exp();
        logic [31:0] pcm;
        exp_t        e;
        op_t         o;
        bit          nop;
        pcm = RESET_PC;
        expq.delete();
        last_fault = 1'b0;
        foreach (prog[i]) begin
            o   = prog[i];
            nop = (o.instr == 32'h0);
            e.addr = pcm; e.instr = o.instr; e.chk_instr = 1'b1;
            e.rf = 1'b0; e.we = 1'b0; e.flt = 1'b0; e.alu = 0; e.dm = 0;
            if (o.wf >= TIMEOUT) begin
                e.flt = 1'b1; e.chk_instr = 1'b0; e.lat = TIMEOUT + 1;
            end else begin
                e.lat = o.wf + 3;
                if (!nop) begin
                    e.alu = 1;
                    e.lat = e.lat + 1;
                    if (o.rd || o.wr) begin
                        e.we = o.wr;
                        if (o.rd && o.wr) begin
                            e.flt = 1'b1; e.dm = 1; e.lat = o.wf + 5;
                        end else if (o.wm >= TIMEOUT) begin
                            e.flt = 1'b1; e.dm = TIMEOUT; e.lat = o.wf + 4 + TIMEOUT;
                        end else begin
                            e.dm = o.wm + 1; e.lat = e.lat + o.wm + 1;
                        end
                    end
                    if (!e.flt && o.jmp && o.tgt[1:0] != 2'b00) begin
                        e.flt = 1'b1; e.lat = e.lat + 1;
                    end
                end
            end
            if (e.flt) begin
                expq.push_back(e);
                last_fault = 1'b1;
                last_fault_pc = pcm;
                break;
            end
            e.rf = !nop && o.rw;
            pcm  = (!nop && o.jmp) ? o.tgt : pcm + 32'd4;
            expq.push_back(e);
        end
    endtask

    // Memory/decoder responder; ready is forced high during reset and toggles randomly while req is low.
    int fi, fcnt, dcnt, cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            fi = 0; fcnt = 0; dcnt = 0; cur = 0;
            imem_ready = 1'b1; dmem_ready = 1'b1; imem_rdata = $urandom();
            dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b0;
            dec_jump = 1'b0; jump_target = 32'h0;
        end else begin
            if (imem_req) begin
                if (fi < prog.size() && fcnt == prog[fi].wf) begin
                    imem_ready = 1'b1; imem_rdata = prog[fi].instr;
                    dec_mem_read = prog[fi].rd; dec_mem_write = prog[fi].wr;
                    dec_reg_write = prog[fi].rw; dec_jump = prog[fi].jmp;
                    jump_target = prog[fi].tgt;
                    cur = fi; fi++; fcnt = 0;
                end else begin
                    imem_ready = 1'b0; imem_rdata = $urandom(); fcnt++;
                end
            end else begin
                imem_ready = 1'($urandom()); imem_rdata = $urandom();
            end
            if (dmem_req && cur < prog.size()) begin
                if (dcnt == prog[cur].wm) begin dmem_ready = 1'b1; dcnt = 0; end
                else begin dmem_ready = 1'b0; dcnt++; end
            end else begin
                dmem_ready = 1'($urandom());
            end
        end
    end

    // Monitor: pops the scoreboard on every retire pulse or fault rising edge.
    int   start, alu_c, dm_c;
    logic we_seen, prev_req, prev_flt;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_req = 1'b0; prev_flt = 1'b0; alu_c = 0; dm_c = 0; we_seen = 1'b0; start = cyc;
        end else begin
            if (imem_req && !prev_req) begin
                start = cyc; alu_c = 0; dm_c = 0; we_seen = 1'b0;
                if (expq.size() > 0) chk("fetch_addr", imem_addr, expq[0].addr);
            end
            prev_req = imem_req;
            if (alu_en) alu_c++;
            if (dmem_req) begin dm_c++; we_seen = we_seen | dmem_we; end
            if (retire || (fault && !prev_flt)) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event: retire=%b fault=%b pc=%0h", retire, fault, pc);
                end else begin
                    e = expq.pop_front();
                    chk("fault", 32'(fault), 32'(e.flt));
                    chk("retire", 32'(retire), 32'(!e.flt));
                    chk("pc", pc, e.addr);
                    if (e.chk_instr) chk("instruction", instruction, e.instr);
                    chk("rf_write", 32'(rf_write), 32'(e.rf));
                    chk("alu_cycles", 32'(alu_c), 32'(e.alu));
                    chk("dmem_cycles", 32'(dm_c), 32'(e.dm));
                    chk("dmem_we", 32'(we_seen), 32'(e.we));
                    chk("latency", 32'(cyc - start + 1), 32'(e.lat));
                end
            end else if (rf_write) begin
                checks++; failures++;
                $display("FAIL rf_write_without_retire: pc=%0h", pc);
            end
            prev_flt = fault;
        end
    end

    task automatic chk_reset();
        chk("reset_pc", pc, RESET_PC);
        chk("reset_instruction", instruction, 32'h0);
        chk("reset_strobes", {25'd0, imem_req, dmem_req, dmem_we, alu_en, rf_write, retire, fault}, 32'h0);
    endtask

    task automatic start_prog();
        rst_n = 1'b0;
        build_exp();
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        #1 chk("idle_no_req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1 chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, RESET_PC);
    endtask

    task automatic finish_prog();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++; failures++;
            $display("FAIL phase_timeout: %0d expected events outstanding", expq.size());
        end
        if (last_fault) begin
            repeat (3) begin
                @(negedge clk);
                chk("fault_sticky", 32'(fault), 32'h1);
                chk("fault_no_retire", 32'(retire), 32'h0);
                chk("fault_pc_hold", pc, last_fault_pc);
            end
        end
    endtask

    task automatic gen_random(input int n, input bit end_fault);
        logic [31:0] t;
        int          k, wf, wm;
        prog.delete();
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 4);
            t  = $urandom();
            t[1:0] = 2'b00;
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : 0;
            wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : 0;
            prog.push_back(mk(k, t, wf, wm));
        end
        if (end_fault) begin
            case ($urandom_range(0, 3))
                0: prog.push_back(mk(1, 32'h0, TIMEOUT + 2, 0));
                1: prog.push_back(mk(3, 32'h0, 0, TIMEOUT + 3));
                2: prog.push_back(mk(5, 32'h0, 1, 0));
                default: prog.push_back(mk(4, 32'h0000_0203, 0, 0));
            endcase
        end
    endtask

    initial begin
        int n;
        prog.delete();
        repeat (3) prog.push_back(mk(1, 32'h0, 0, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(2, 32'h0, 0, 3));
        prog.push_back(mk(1, 32'h0, 0, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(4, 32'h0000_0100, 0, 0));
        prog.push_back(mk(1, 32'h0, 0, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(1, 32'h0, 0, 0));
        prog.push_back(mk(4, 32'h0000_0102, 0, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(1, 32'h0, TIMEOUT, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(1, 32'h0, TIMEOUT - 1, 0));
        prog.push_back(mk(3, 32'h0, 0, TIMEOUT - 1));
        prog.push_back(mk(5, 32'h0, 0, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(4, 32'hFFFF_FFFC, 0, 0));
        prog.push_back(mk(0, 32'h0, 0, 0));
        prog.push_back(mk(1, 32'h0, 0, 0));
        start_prog(); finish_prog();

        prog.delete();
        prog.push_back(mk(2, 32'h0, 0, 40));
        start_prog();
        n = 0;
        while (!dmem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_mem_reached", 32'(dmem_req), 32'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset();

        gen_random(60, 1'b0);
        start_prog(); finish_prog();
        gen_random(20, 1'b1);
        start_prog(); finish_prog();
        gen_random(20, 1'b1);
        start_prog(); finish_prog();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

// File: doc/rv32_multicycle_sequencer.md
# rv32_multicycle_sequencer

Multi-cycle state machine that sequences the RV32 datapath one instruction at a time: it fetches from instruction memory, holds the instruction for the decoder, and steps the ALU, data memory and register-file write. It reads the decoder's enable and jump outputs to choose the path, owns the program counter, and enforces a bounded req/ready handshake on both memory ports.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum wait cycles for a memory ready. 0 disables the timeout.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address; always equals pc
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instruction  out  32  latched instruction register, drives the decoder
- dec_mem_read  in  1  decoder: instruction is a load
- dec_mem_write  in  1  decoder: instruction is a store
- dec_reg_write  in  1  decoder: instruction writes rd
- dec_jump  in  1  decoder: instruction is JAL/JALR
- jump_target  in  32  computed jump address
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ready  in  1  data access complete
- alu_en  out  1  ALU operand/result capture strobe
- rf_write  out  1  register-file write strobe
- pc  out  32  current program counter
- retire  out  1  one-cycle pulse per completed instruction
- fault  out  1  sticky error flag

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT. State is registered; outputs are decoded from state.
- **IDLE** (reset state): all strobes 0. Always moves to FETCH on the next cycle.
- **FETCH**:
  - imem_req=1.
  - If imem_ready=1: instruction<=imem_rdata and go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: one cycle; decoder outputs settle.
  - instruction==0: treat as NOP and go to WRITEBACK.
  - Otherwise go to EXECUTE.
- **EXECUTE**: alu_en=1 for one cycle.
  - If dec_mem_read or dec_mem_write: go to MEM.
  - Otherwise go to WRITEBACK.
- **MEM**:
  - dmem_req=1; dmem_we=dec_mem_write.
  - If dmem_ready=1: go to WRITEBACK.
  - Otherwise stay in MEM.
  - dec_mem_read and dec_mem_write both 1: go to FAULT.
- **WRITEBACK**:
  - rf_write=dec_reg_write (suppressed for a NOP); retire=1.
  - PC update: pc<=jump_target if dec_jump, else pc+4. Addition is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - If dec_jump and jump_target[1:0]!=0: go to FAULT and leave pc unchanged. No retire and no rf_write in this case.
  - Otherwise go to FETCH.
- **Timeout**:
  - wait_cnt increments each cycle in FETCH or MEM while ready=0, and clears on any state change.
  - If TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with ready still 0: go to FAULT next cycle.
  - ready=1 in that same cycle wins; no fault.
- **FAULT**: fault=1; all strobes 0; pc holds. Exit only by reset.
- The instruction register holds its value from capture until the next FETCH capture.

## Timing
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, pc=RESET_PC, instruction=0.
  - imem_req, dmem_req, dmem_we, alu_en, rf_write, retire and fault all 0; wait_cnt=0.
- First imem_req is asserted in the 2nd rising edge's cycle after rst_n deasserts (IDLE lasts one cycle).
- Handshake:
  - req stays high, and addr/we stay stable, until ready is sampled 1 at a rising edge.
  - req drops the cycle after ready is sampled 1.
  - ready while req=0 is ignored.
- Latency with ready=1 on the first request cycle:
  - ALU/jump/NOP: 4 cycles per instruction (NOP skips EXECUTE: 3 cycles).
  - load/store: 5 cycles per instruction.
  - retire spacing is the same as the latency.
- pc changes only on the edge leaving WRITEBACK. imem_addr reflects the new pc in the following FETCH.
- Reset asserted mid-operation: immediate return to the reset values. An outstanding request is abandoned, and a late ready is ignored.

## Test plan
- **Reset release, straight-line code:** RESET_PC=0; memory returns ADD (R-type) with ready every cycle -> imem_req at cycle 2; retire every 4 cycles; imem_addr sequence 0, 4, 8; rf_write=1 once per retire.
- **Load with wait states:** LW with dmem_ready delayed 3 cycles -> dmem_req high for exactly 4 cycles with dmem_we=0; retire 8 cycles after fetch start; pc advances by 4.
- **Jump:**
  - JAL with jump_target=32'h0000_0100 -> next imem_addr=0x100.
  - jump_target=32'h0000_0102 -> fault=1, pc unchanged, no retire.
- **Timeout:**
  - TIMEOUT=16, imem_ready held 0 -> fault asserts after 16 request cycles.
  - Repeat with ready arriving on the 16th cycle -> no fault; DECODE follows.
- **NOP and wrap:** pc=32'hFFFF_FFFC fetching 32'h0 -> no alu_en, no rf_write, retire=1, next pc=0.
- **Reset mid-MEM:** assert rst_n=0 while dmem_req=1 -> all outputs reset immediately; dmem_ready pulse during reset causes no state change.
